// File: rtl/traffic_light_controller_nway_pkg.sv
// tlc_pkg: state encoding and lamp codes shared by the N-way traffic controller
// Contents: state_t (GREEN, YELLOW, ALLRED, EMERG_GREEN), LT_GREEN/LT_YELLOW/LT_RED lamp codes
package tlc_pkg;
   localparam logic [1:0] S_GREEN  = 2'd0;
   localparam logic [1:0] S_YELLOW = 2'd1;
   localparam logic [1:0] S_ALLRED = 2'd2;
   localparam logic [1:0] S_EMERG  = 2'd3;
   typedef enum logic [1:0] {
      ST_GREEN  = S_GREEN,
      ST_YELLOW = S_YELLOW,
      ST_ALLRED = S_ALLRED,
      ST_EMERG  = S_EMERG
   } state_t;
   localparam logic [2:0] LT_GREEN  = 3'b001;
   localparam logic [2:0] LT_YELLOW = 3'b010;
   localparam logic [2:0] LT_RED    = 3'b100;
endpackage

// File: rtl/traffic_light_controller_nway_if.sv
// tlc_if: request/density inputs and lamp/status outputs of the N-way controller
// master: drives amb, density; reads lights, active_dir, emergency_mode
// slave:  the controller side
interface tlc_if #(
   parameter int NUM_DIR = 4,
   parameter int DENS_W  = 4
);
   localparam int AW = $clog2(NUM_DIR);
   logic [NUM_DIR-1:0]        amb;
   logic [NUM_DIR*DENS_W-1:0] density;
   logic [3*NUM_DIR-1:0]      lights;
   logic [AW-1:0]             active_dir;
   logic                      emergency_mode;
   modport master (output amb, density, input lights, active_dir, emergency_mode);
   modport slave (input amb, density, output lights, active_dir, emergency_mode);
endinterface

// File: rtl/traffic_light_controller_nway_dir_select.sv
// tlc_dir_select: combinational picker for the emergency target and the next approach in rotation
// Ports: amb, density, active_dir in; emerg_dir (lowest set amb bit), next_dir out
// Optional: TLC_SKIP_EMPTY_EN skips approaches whose density is zero
module tlc_dir_select
   import tlc_pkg::*;
#(
   parameter int NUM_DIR = 4,
   parameter int DENS_W  = 4,
   localparam int AW     = $clog2(NUM_DIR)
)(
   input  logic [NUM_DIR-1:0]        amb,
   input  logic [NUM_DIR*DENS_W-1:0] density,
   input  logic [AW-1:0]             active_dir,
   output logic [AW-1:0]             emerg_dir,
   output logic [AW-1:0]             next_dir
);
   logic [AW-1:0] rr_dir;
   always_comb begin
      emerg_dir = '0;
      for (int i = NUM_DIR - 1; i >= 0; i--)
         if (amb[i]) emerg_dir = AW'(i);
   end
   assign rr_dir = (int'(active_dir) + 1 >= NUM_DIR) ? '0 : AW'(int'(active_dir) + 1);
`ifdef TLC_SKIP_EMPTY_EN
   // Scan descending so the nearest non-empty approach after active_dir wins; k = NUM_DIR is active_dir itself
   always_comb begin
      int idx;
      idx = 0;
      next_dir = rr_dir;
      for (int k = NUM_DIR; k >= 1; k--) begin
         idx = int'(active_dir) + k;
         if (idx >= NUM_DIR) idx = idx - NUM_DIR;
         if (density[idx*DENS_W +: DENS_W] != '0) next_dir = AW'(idx);
      end
   end
`else
   logic unused_density;
   assign unused_density = ^density;
   assign next_dir = rr_dir;
`endif
endmodule

// File: rtl/traffic_light_controller_nway.sv
// traffic_light_controller_nway: N-approach adaptive signal controller with density-scaled greens and emergency preemption
// Ports: clk, rst_a (synchronous, active-high), bus (tlc_if.slave: amb, density in; lights, active_dir, emergency_mode out)
// Optional: TLC_SKIP_EMPTY_EN makes normal rotation skip approaches with zero density
module traffic_light_controller_nway
   import tlc_pkg::*;
#(
   parameter int NUM_DIR     = 4,
   parameter int DENS_W      = 4,
   parameter int MIN_GREEN   = 2,
   parameter int MAX_GREEN   = 12,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1
)(
   input logic  clk,
   input logic  rst_a,
   tlc_if.slave bus
);
   localparam int AW = $clog2(NUM_DIR);
   localparam int TW = $clog2(MAX_GREEN + YELLOW_TIME + ALLRED_TIME + 1);
   state_t               state;
   logic [TW-1:0]        timer;
   logic [3*NUM_DIR-1:0] lights;
   logic [AW-1:0]        active_dir, emerg_dir, next_dir;
   logic                 emergency_mode, any_amb, last;
   logic [DENS_W-1:0]    next_dens;
   logic [DENS_W:0]      green_sum;
   logic [TW-1:0]        green_len;
   function automatic logic [3*NUM_DIR-1:0] lamp(input logic [AW-1:0] d, input logic [2:0] c);
      lamp = {NUM_DIR{LT_RED}};
      lamp[3*int'(d) +: 3] = c;
   endfunction
   tlc_dir_select #(.NUM_DIR(NUM_DIR), .DENS_W(DENS_W)) u_sel (
      .amb        (bus.amb),
      .density    (bus.density),
      .active_dir (active_dir),
      .emerg_dir  (emerg_dir),
      .next_dir   (next_dir)
   );
   assign any_amb   = |bus.amb;
   assign last      = timer == TW'(1);
   assign next_dens = bus.density[int'(next_dir)*DENS_W +: DENS_W];
   // One bit wider than the density so the sum cannot wrap before the clamp
   assign green_sum = {1'b0, next_dens} + (DENS_W+1)'(MIN_GREEN);
   assign green_len = (int'(green_sum) > MAX_GREEN) ? TW'(MAX_GREEN) : TW'(green_sum);
   assign bus.lights         = lights;
   assign bus.active_dir     = active_dir;
   assign bus.emergency_mode = emergency_mode;
   always_ff @(posedge clk) begin
      if (rst_a) begin
         state          <= ST_ALLRED;
         timer          <= TW'(ALLRED_TIME);
         lights         <= {NUM_DIR{LT_RED}};
         active_dir     <= AW'(NUM_DIR - 1);
         emergency_mode <= 1'b0;
      end else begin
         case (state)
            ST_GREEN: begin
               // An emergency on the approach already green is entered without touching the lamp
               if (any_amb && emerg_dir == active_dir) begin
                  state          <= ST_EMERG;
                  emergency_mode <= 1'b1;
               end else if (any_amb || last) begin
                  state  <= ST_YELLOW;
                  timer  <= TW'(YELLOW_TIME);
                  lights <= lamp(active_dir, LT_YELLOW);
               end else
                  timer <= timer - TW'(1);
            end
            ST_YELLOW: begin
               if (last) begin
                  state  <= ST_ALLRED;
                  timer  <= TW'(ALLRED_TIME);
                  lights <= {NUM_DIR{LT_RED}};
               end else
                  timer <= timer - TW'(1);
            end
            ST_ALLRED: begin
               if (last && any_amb) begin
                  state          <= ST_EMERG;
                  active_dir     <= emerg_dir;
                  lights         <= lamp(emerg_dir, LT_GREEN);
                  emergency_mode <= 1'b1;
               end else if (last) begin
                  state      <= ST_GREEN;
                  active_dir <= next_dir;
                  timer      <= green_len;
                  lights     <= lamp(next_dir, LT_GREEN);
               end else
                  timer <= timer - TW'(1);
            end
            ST_EMERG: begin
               // Only the served approach's request matters here; other requests wait for clearance
               if (!bus.amb[active_dir]) begin
                  state          <= ST_YELLOW;
                  timer          <= TW'(YELLOW_TIME);
                  lights         <= lamp(active_dir, LT_YELLOW);
                  emergency_mode <= 1'b0;
               end
            end
            default: state <= ST_ALLRED;
         endcase
      end
   end
endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// tb_traffic_light_controller_nway: table-driven directed bench for the N-way traffic controller
module tb_traffic_light_controller_nway;
   localparam logic [11:0] R  = 12'h924;
   localparam logic [11:0] G0 = 12'h921, Y0 = 12'h922;
   localparam logic [11:0] G1 = 12'h90C, Y1 = 12'h914;
   localparam logic [11:0] G2 = 12'h864, Y2 = 12'h8A4;
   localparam logic [11:0] G3 = 12'h324, Y3 = 12'h524;
   typedef struct {
      logic        rst;
      logic [3:0]  amb;
      logic [15:0] dens;
      int          n;
      logic [11:0] lt;
      logic [1:0]  dir;
      logic        em;
   } vec_t;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   int checks = 0;
   int failures = 0;
   vec_t tbl[$];
   always #5 clk = ~clk;
   tlc_if #(.NUM_DIR(4), .DENS_W(4)) bus();
   traffic_light_controller_nway dut (
      .clk   (clk),
      .rst_a (rst_a),
      .bus   (bus)
   );
   task automatic add(input logic r, input logic [3:0] a, input logic [15:0] d, input int n,
                      input logic [11:0] lt, input logic [1:0] dir, input logic em);
      vec_t v;
      v.rst = r; v.amb = a; v.dens = d; v.n = n; v.lt = lt; v.dir = dir; v.em = em;
      tbl.push_back(v);
   endtask
   task automatic drive(input logic r, input logic [3:0] a, input logic [15:0] d);
      rst_a = r;
      bus.amb = a;
      bus.density = d;
   endtask
   task automatic step_chk(input string nm, input logic [11:0] lt, input logic [1:0] dir, input logic em);
      @(posedge clk);
      #1;
      checks++;
      if (bus.lights !== lt) begin
         failures++;
         $display("FAIL %s lights got=%h want=%h t=%0t", nm, bus.lights, lt, $time);
      end
      checks++;
      if (bus.active_dir !== dir) begin
         failures++;
         $display("FAIL %s active_dir got=%0d want=%0d t=%0t", nm, bus.active_dir, dir, $time);
      end
      checks++;
      if (bus.emergency_mode !== em) begin
         failures++;
         $display("FAIL %s emergency_mode got=%b want=%b t=%0t", nm, bus.emergency_mode, em, $time);
      end
   endtask
   initial begin
      drive(1'b1, 4'h0, 16'h8888);
      add(1, 4'h0, 16'h8888,  3, R,  2'd3, 0);
      add(0, 4'h0, 16'h8888, 10, G0, 2'd0, 0);
      add(0, 4'h0, 16'h8888,  2, Y0, 2'd0, 0);
      add(0, 4'h0, 16'h8888,  1, R,  2'd0, 0);
      add(0, 4'h0, 16'h8888, 10, G1, 2'd1, 0);
      add(0, 4'h0, 16'h8888,  2, Y1, 2'd1, 0);
      add(0, 4'h0, 16'h8888,  1, R,  2'd1, 0);
      add(0, 4'h0, 16'h8888, 10, G2, 2'd2, 0);
      add(0, 4'h0, 16'h8888,  2, Y2, 2'd2, 0);
      add(0, 4'h0, 16'h8888,  1, R,  2'd2, 0);
      add(0, 4'h0, 16'h8888, 10, G3, 2'd3, 0);
      add(0, 4'h0, 16'h8888,  2, Y3, 2'd3, 0);
      add(0, 4'h0, 16'h8888,  1, R,  2'd3, 0);
      add(0, 4'h0, 16'h830F, 12, G0, 2'd0, 0);
      add(0, 4'h0, 16'h830F,  2, Y0, 2'd0, 0);
      add(0, 4'h0, 16'h830F,  1, R,  2'd0, 0);
      add(0, 4'h0, 16'h830F,  2, G1, 2'd1, 0);
      add(0, 4'h0, 16'h830F,  2, Y1, 2'd1, 0);
      add(0, 4'h0, 16'h830F,  1, R,  2'd1, 0);
      add(0, 4'h0, 16'h830F,  5, G2, 2'd2, 0);
      add(0, 4'h0, 16'h830F,  2, Y2, 2'd2, 0);
      add(0, 4'h0, 16'h830F,  1, R,  2'd2, 0);
      add(0, 4'h0, 16'h830F, 10, G3, 2'd3, 0);
      add(0, 4'h0, 16'h830F,  2, Y3, 2'd3, 0);
      add(0, 4'h0, 16'h830F,  1, R,  2'd3, 0);
      add(0, 4'h0, 16'h8888,  4, G0, 2'd0, 0);
      add(0, 4'h4, 16'h8888,  2, Y0, 2'd0, 0);
      add(0, 4'h4, 16'h8888,  1, R,  2'd0, 0);
      add(0, 4'h4, 16'h8888,  3, G2, 2'd2, 1);
      add(0, 4'h0, 16'h8888,  2, Y2, 2'd2, 0);
      add(0, 4'h0, 16'h8888,  1, R,  2'd2, 0);
      add(0, 4'h0, 16'h8888,  3, G3, 2'd3, 0);
      add(0, 4'h9, 16'h8888,  2, Y3, 2'd3, 0);
      add(0, 4'h9, 16'h8888,  1, R,  2'd3, 0);
      add(0, 4'h9, 16'h8888,  2, G0, 2'd0, 1);
      add(0, 4'h8, 16'h8888,  2, Y0, 2'd0, 0);
      add(0, 4'h8, 16'h8888,  1, R,  2'd0, 0);
      add(0, 4'h8, 16'h8888,  2, G3, 2'd3, 1);
      add(0, 4'h9, 16'h8888,  2, G3, 2'd3, 1);
      add(1, 4'h9, 16'h8888,  1, R,  2'd3, 0);
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].amb, tbl[i].dens);
         for (int k = 0; k < tbl[i].n; k++)
            step_chk($sformatf("row%0d", i), tbl[i].lt, tbl[i].dir, tbl[i].em);
      end
      // Request for the green approach arriving on its last green cycle becomes an emergency green
      drive(1'b0, 4'h0, 16'h8888);
      for (int k = 0; k < 10; k++) step_chk("post_rst_g0", G0, 2'd0, 0);
      drive(1'b0, 4'h1, 16'h8888);
      step_chk("last_cyc_same", G0, 2'd0, 1);
      step_chk("last_cyc_hold", G0, 2'd0, 1);
      drive(1'b0, 4'h0, 16'h8888);
      step_chk("emerg_end_y", Y0, 2'd0, 0);
      step_chk("emerg_end_y", Y0, 2'd0, 0);
      step_chk("emerg_end_r", R, 2'd0, 0);
      for (int k = 0; k < 10; k++) step_chk("resume_g1", G1, 2'd1, 0);
      // Other-approach request on the last green cycle: yellow, clearance, lowest-index emergency
      drive(1'b0, 4'hC, 16'h8888);
      step_chk("last_cyc_other_y", Y1, 2'd1, 0);
      step_chk("last_cyc_other_y", Y1, 2'd1, 0);
      step_chk("last_cyc_other_r", R, 2'd1, 0);
      step_chk("lowest_idx_emerg", G2, 2'd2, 1);
`ifdef TLC_SKIP_EMPTY_EN
      drive(1'b0, 4'h0, 16'h0050);
      step_chk("skip_y2", Y2, 2'd2, 0);
      step_chk("skip_y2", Y2, 2'd2, 0);
      step_chk("skip_r2", R, 2'd2, 0);
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 7; k++) step_chk("skip_g1", G1, 2'd1, 0);
         step_chk("skip_y1", Y1, 2'd1, 0);
         step_chk("skip_y1", Y1, 2'd1, 0);
         if (p == 1) drive(1'b0, 4'h0, 16'h0000);
         step_chk("skip_r1", R, 2'd1, 0);
      end
      for (int k = 0; k < 2; k++) step_chk("empty_g2", G2, 2'd2, 0);
      for (int k = 0; k < 2; k++) step_chk("empty_y2", Y2, 2'd2, 0);
      step_chk("empty_r2", R, 2'd2, 0);
      for (int k = 0; k < 2; k++) step_chk("empty_g3", G3, 2'd3, 0);
      for (int k = 0; k < 2; k++) step_chk("empty_y3", Y3, 2'd3, 0);
      step_chk("empty_r3", R, 2'd3, 0);
      step_chk("empty_g0", G0, 2'd0, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
